pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It sequences the ID/EX pipeline register and its IF/ID and EX/MEM neighbours by generating the per-stage enables, flushes and the ID/EX bubble (`id_stall`). It handles four cases: load-use hazards, taken branch/jump redirects resolved in EX, multi-cycle mul/div occupancy of EX, and data-memory back-pressure. It also keeps a watchdog on mul/div and a stall-cycle performance counter.

## Interface
Parameters:
- `MULDIV_MAX_CYC`, 34, watchdog limit in MD_WAIT cycles; range 2..255.

Ports:
- `clk` in 1, core clock; all state updates on the rising edge.
- `rst_n` in 1, asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `id_valid` in 1, ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5, source register indices in ID.
- `id_use_rs1`, `id_use_rs2` in 1, ID instruction actually reads rs1 / rs2.
- `ex_valid` in 1, EX holds a real instruction (not a bubble).
- `ex_rd` in 5, EX destination register.
- `ex_reg_we` in 1, EX writes the register file.
- `ex_mem_re` in 1, EX is a load.
- `ex_redirect` in 1, branch/jump taken, resolved in EX.
- `ex_muldiv_start` in 1, mul/div operation issued in EX this cycle.
- `muldiv_done` in 1, mul/div result valid.
- `mem_busy` in 1, data memory not ready.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1, stage advance enables.
- `if_id_flush`, `id_ex_flush` out 1, stage flushes.
- `id_stall` out 1, loads a bubble into ID/EX.
- `ctrl_state` out 2, FSM state: 0 = RUN, 1 = MD_WAIT, 2 = MEM_WAIT.
- `muldiv_timeout` out 1, one-cycle watchdog pulse.
- `stall_cnt` out 16, registered count of stall cycles.

## Operation
- Outputs are Mealy-combinational from the registered state and current inputs. `state`, `md_cnt` and `stall_cnt` are registered.
- Default in RUN with no event: all four enables = 1; `if_id_flush`, `id_ex_flush`, `id_stall`, `muldiv_timeout` = 0.
- RUN priority, highest first:
  1. `mem_busy`: all enables 0, next state MEM_WAIT.
  2. `ex_redirect`: `pc_en` = 1, `if_id_flush` = 1, `id_ex_flush` = 1, other enables 1, `id_stall` = 0. Stay in RUN. Redirect overrides load-use.
  3. `ex_muldiv_start` & !`muldiv_done`: all enables 0, next state MD_WAIT, `md_cnt` <= 0. If start and done arrive together, there is no stall.
  4. Load-use: `id_valid` & `ex_valid` & `ex_mem_re` & `ex_reg_we` & (`ex_rd` != 0) & ((`id_use_rs1` & `id_rs1` == `ex_rd`) | (`id_use_rs2` & `id_rs2` == `ex_rd`)). Response: `pc_en` = `if_id_en` = 0, `id_ex_en` = 1, `id_stall` = 1, `ex_mem_en` = 1. Stay in RUN; the hazard clears naturally next cycle.
- MD_WAIT:
  - All enables 0, `md_cnt` increments each cycle.
  - On `muldiv_done`: enables 1, next state RUN. If `mem_busy` is also high, `ex_mem_en` = 0 and next state is MEM_WAIT instead.
  - Timeout: `md_cnt` == `MULDIV_MAX_CYC`-1 & !`muldiv_done` gives `muldiv_timeout` = 1, enables 1, next state RUN.
  - `ex_redirect` and load-use inputs are ignored in MD_WAIT.
- MEM_WAIT:
  - While `mem_busy` = 1: all enables 0.
  - When `mem_busy` = 0: the cycle behaves exactly as RUN, with the same outputs and next-state rules, so there is no dead cycle.
- `stall_cnt` increments on every post-reset cycle with `pc_en` = 0 and saturates at 0xFFFF.
- `md_cnt` is 8 bits wide.

## Timing
- Reset (`rst_n` = 0), asynchronous:
  - `state` = RUN, `md_cnt` = 0, `stall_cnt` = 0.
  - While reset is held, all enables, flushes, `id_stall` and `muldiv_timeout` are forced to 0, and `ctrl_state` = 0.
- First cycle after reset release: RUN defaults.
- Reset asserted mid MD_WAIT or MEM_WAIT aborts immediately to RUN; counters clear.
- Control latency is 0 cycles (same-cycle combinational response). State changes take effect on the next edge.
- A mul/div started at cycle T and done at T+k (k ≥ 1) freezes enables for T..T+k-1 and releases them at T+k. `ctrl_state` = 1 for cycles T+1..T+k.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with random inputs -> enables 0, `stall_cnt` 0, `ctrl_state` 0. After release with idle inputs -> all enables 1, flushes 0.
- Load-use: `ex_mem_re` = `ex_reg_we` = `ex_valid` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_use_rs2` = 1 -> for one cycle `pc_en` = `if_id_en` = 0, `id_stall` = 1, `id_ex_en` = 1, `stall_cnt` +1. Repeat with `ex_rd` = 0, or with `id_use_rs2` = 0 -> no stall.
- Redirect plus load-use in the same cycle -> `if_id_flush` = `id_ex_flush` = 1, `pc_en` = 1, `id_stall` = 0.
- Mul/div: start at T, `muldiv_done` at T+5 -> enables 0 for T..T+4 and 1 at T+5. `ctrl_state` = 1 for T+1..T+5. `stall_cnt` +5.
- Watchdog (`MULDIV_MAX_CYC` = 34): start at T, done never asserted -> `muldiv_timeout` = 1 only at T+34, enables 1 at T+34, `ctrl_state` = 0 at T+35.
- Done during `mem_busy`: in MD_WAIT, assert `muldiv_done` with `mem_busy` = 1 -> `ctrl_state` = 2 next cycle. Drop `mem_busy` with `ex_redirect` = 1 -> flushes 1 that same cycle, `ctrl_state` = 0 next. Then assert `rst_n` = 0 mid MD_WAIT -> `ctrl_state` = 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the ID/EX boundary of the 5-stage core: stage
// enables, flushes, ID/EX bubble, mul/div watchdog and a stall-cycle counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal flow; load-use, redirect, mul/div start, mem stall
// MD_WAIT  | EX occupied by a multi-cycle mul/div, watchdog running
// MEM_WAIT | data memory back-pressure; acts as RUN once mem_busy drops
module pipe_hazard_ctrl #(
  parameter int unsigned MULDIV_MAX_CYC = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_mem_re,
  input  logic        ex_redirect,
  input  logic        ex_muldiv_start,
  input  logic        muldiv_done,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_stall,
  output logic [1:0]  ctrl_state,
  output logic        muldiv_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MD_LAST = 8'(MULDIV_MAX_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [3:0]  en_c;  // {pc, if_id, id_ex, ex_mem}
  logic        if_id_flush_c, id_ex_flush_c, id_stall_c, timeout_c;
  logic        load_use;

  assign load_use = id_valid && ex_valid && ex_mem_re && ex_reg_we && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    en_c          = 4'b1111;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    id_stall_c    = 1'b0;
    timeout_c     = 1'b0;
    case (state_q)
      ST_MD_WAIT: begin
        md_cnt_d = md_cnt_q + 8'd1;
        if (muldiv_done) begin
          if (mem_busy) begin
            en_c    = 4'b1110;
            state_d = ST_MEM_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (md_cnt_q == MD_LAST) begin
          timeout_c = 1'b1;
          state_d   = ST_RUN;
        end else begin
          en_c = 4'b0000;
        end
      end
      // MEM_WAIT without back-pressure takes the RUN path so no cycle is lost
      default: begin
        state_d = ST_RUN;
        if (mem_busy) begin
          en_c    = 4'b0000;
          state_d = ST_MEM_WAIT;
        end else if (ex_redirect) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (ex_muldiv_start && !muldiv_done) begin
          en_c     = 4'b0000;
          state_d  = ST_MD_WAIT;
          md_cnt_d = 8'd0;
        end else if (load_use) begin
          en_c       = 4'b0011;
          id_stall_c = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en_c[3] && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are held inactive for as long as reset is asserted.
  assign pc_en          = rst_n & en_c[3];
  assign if_id_en       = rst_n & en_c[2];
  assign id_ex_en       = rst_n & en_c[1];
  assign ex_mem_en      = rst_n & en_c[0];
  assign if_id_flush    = rst_n & if_id_flush_c;
  assign id_ex_flush    = rst_n & id_ex_flush_c;
  assign id_stall       = rst_n & id_stall_c;
  assign muldiv_timeout = rst_n & timeout_c;
  assign ctrl_state     = state_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int MAXC = 34;
  localparam int M_RUN = 0, M_MD = 1, M_MEM = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_reg_we, ex_mem_re;
  logic ex_redirect, ex_muldiv_start, muldiv_done, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, id_stall, muldiv_timeout;
  logic [1:0] ctrl_state;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.MULDIV_MAX_CYC(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start),
    .muldiv_done(muldiv_done), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .id_stall(id_stall),
    .ctrl_state(ctrl_state), .muldiv_timeout(muldiv_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [25:0] exp_q[$];
  string       tag_q[$];
  int checks = 0;
  int errors = 0;

  // model state: current mode, MD_WAIT cycles elapsed, stall cycles seen
  int m_mode = M_RUN;
  int m_age  = 0;
  int m_stalls = 0;

  task automatic model_push(input string tag);
    bit pc, ifid, idex, exm, fl, stl, tmo, hz;
    int nxt;
    int cur_stalls;
    pc = 1; ifid = 1; idex = 1; exm = 1; fl = 0; stl = 0; tmo = 0;
    if (!rst_n) begin
      m_mode = M_RUN; m_age = 0; m_stalls = 0;
      exp_q.push_back(26'd0);
      tag_q.push_back(tag);
      return;
    end
    hz = id_valid && ex_valid && ex_mem_re && ex_reg_we && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    nxt = M_RUN;
    if (m_mode == M_MD) begin
      if (muldiv_done) begin
        if (mem_busy) begin exm = 0; nxt = M_MEM; end
      end else if (m_age == MAXC) begin
        tmo = 1;
      end else begin
        {pc, ifid, idex, exm} = 4'b0000;
        nxt = M_MD;
      end
      m_age++;
    end else if (mem_busy) begin
      {pc, ifid, idex, exm} = 4'b0000;
      nxt = M_MEM;
    end else if (ex_redirect) begin
      fl = 1;
    end else if (ex_muldiv_start && !muldiv_done) begin
      {pc, ifid, idex, exm} = 4'b0000;
      nxt = M_MD;
      m_age = 1;
    end else if (hz) begin
      pc = 0; ifid = 0; stl = 1;
    end
    cur_stalls = m_stalls;
    if (!pc && m_stalls < 65535) m_stalls++;
    exp_q.push_back({pc, ifid, idex, exm, fl, fl, stl, 2'(m_mode), tmo, 16'(cur_stalls)});
    tag_q.push_back(tag);
    m_mode = nxt;
  endtask

  // Push this cycle's expectation, then advance to the next drive point.
  task automatic cyc(input string tag);
    model_push(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1; id_use_rs2 = 1;
    ex_valid = 1; ex_rd = 5'd9; ex_reg_we = 1; ex_mem_re = 0;
    ex_redirect = 0; ex_muldiv_start = 0; muldiv_done = 0; mem_busy = 0;
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom_range(0, 1));
    id_use_rs2 = 1'($urandom_range(0, 1));
    ex_valid = ($urandom_range(0, 7) != 0);
    ex_rd = 5'($urandom_range(0, 3));
    ex_reg_we = ($urandom_range(0, 3) != 0);
    ex_mem_re = 1'($urandom_range(0, 1));
    ex_redirect = ($urandom_range(0, 7) == 0);
    ex_muldiv_start = ($urandom_range(0, 9) == 0);
    muldiv_done = ($urandom_range(0, 5) == 0);
    mem_busy = ($urandom_range(0, 5) == 0);
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  initial begin
    logic [25:0] act, exp;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, id_stall,
               ctrl_state, muldiv_timeout, stall_cnt};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s t=%0t got en=%b fl=%b stall=%b st=%0d tmo=%b cnt=%0d want en=%b fl=%b stall=%b st=%0d tmo=%b cnt=%0d",
                   tag, $time, act[25:22], act[21:20], act[19], act[18:17], act[16], act[15:0],
                   exp[25:22], exp[21:20], exp[19], exp[18:17], exp[16], exp[15:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin rand_inputs(); cyc("reset_hold"); end
    rst_n = 1;
    idle_inputs();
    cyc("reset_release");
    cyc("idle");

    // load-use on rs2, then the two non-hazard variants
    ex_mem_re = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
    cyc("load_use");
    ex_rd = 5'd0; id_rs2 = 5'd0;
    cyc("load_use_x0");
    ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 0;
    cyc("load_use_unused");
    id_use_rs2 = 1; ex_redirect = 1;
    cyc("redirect_over_load_use");
    idle_inputs();
    cyc("idle");

    // mul/div with done at T+5
    ex_muldiv_start = 1;
    cyc("md_start");
    ex_muldiv_start = 0;
    for (int i = 0; i < 4; i++) cyc("md_wait");
    muldiv_done = 1;
    cyc("md_done");
    muldiv_done = 0;
    cyc("md_after");
    ex_muldiv_start = 1; muldiv_done = 1;
    cyc("md_start_and_done");
    idle_inputs();

    // watchdog
    ex_muldiv_start = 1;
    cyc("wd_start");
    ex_muldiv_start = 0;
    for (int i = 0; i < MAXC + 3; i++) cyc("wd_wait");

    // done while memory busy, then redirect as back-pressure drops
    ex_muldiv_start = 1;
    cyc("mdm_start");
    ex_muldiv_start = 0;
    cyc("mdm_wait");
    cyc("mdm_wait");
    muldiv_done = 1; mem_busy = 1;
    cyc("mdm_done_busy");
    muldiv_done = 0;
    cyc("mem_wait");
    mem_busy = 0; ex_redirect = 1;
    cyc("mem_release_redirect");
    ex_redirect = 0;
    cyc("after_redirect");
    ex_muldiv_start = 1;
    cyc("md_start_rst");
    ex_muldiv_start = 0;
    cyc("md_wait_rst");
    rst_n = 0;
    cyc("reset_mid_md");
    rst_n = 1;
    cyc("reset_mid_md_release");

    // random traffic with rare resets
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 299) != 0);
      cyc("random");
    end
    rst_n = 1;
    idle_inputs();
    cyc("final_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
